// File: rtl/dc_router_pkg.sv
// ============================================================================
// dc_router_pkg : shared constants, FSM encoding and helpers for the RAM port arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package dc_router_pkg;

   localparam int N_REQ  = 6;
   localparam int ADDR_W = 32;
   localparam int ID_W   = 3;

   localparam int REQ_FFT_RD = 0;
   localparam int REQ_FFT_WR = 1;
   localparam int REQ_FIR_RD = 2;
   localparam int REQ_FIR_WR = 3;
   localparam int REQ_IIR_RD = 4;
   localparam int REQ_IIR_WR = 5;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_BURST = 2'd1,
      ARB_TURN  = 2'd2
   } arb_state_e;

   // Write streams sit on the odd indices.
   function automatic logic is_write(input logic [ID_W-1:0] idx);
      return idx[0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : rotating priority encoder, first set request after `last`, wrapping
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
   import dc_router_pkg::*;
(
   input  logic [N_REQ-1:0] eff_req_i,
   input  logic [ID_W-1:0]  last_i,
   output logic             found_o,
   output logic [ID_W-1:0]  winner_o
);

   logic [ID_W:0] idx;

   // Scan from farthest to nearest so the nearest candidate after `last` wins.
   always_comb begin
      found_o  = 1'b0;
      winner_o = '0;
      idx      = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = {1'b0, last_i} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(N_REQ)) begin
            idx = idx - (ID_W+1)'(N_REQ);
         end
         if (eff_req_i[idx[ID_W-1:0]]) begin
            found_o  = 1'b1;
            winner_o = idx[ID_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// ram_port_arbiter : round-robin burst arbiter for the shared RAM address port
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_port_arbiter
   import dc_router_pkg::*;
#(
   parameter int BURST_MAX = 4
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              acc_en,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        grant,
   output logic [ID_W-1:0]         grant_id,
   output logic                    busy,
   output logic                    ram_read_enable,
   output logic                    ram_write_enable,
   output logic [ADDR_W-1:0]       addr
);

   localparam int          CNT_W     = 4;
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

   arb_state_e         state_q;
   logic [N_REQ-1:0]   grant_q;
   logic [ID_W-1:0]    grant_id_q;
   logic [ID_W-1:0]    last_q;
   logic               busy_q;
   logic               rd_en_q;
   logic               wr_en_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [CNT_W-1:0]   beat_cnt_q;

   logic [N_REQ-1:0]   eff_req;
   logic               pick_found;
   logic [ID_W-1:0]    pick_id;

   assign eff_req = req & {acc_en[2], acc_en[2], acc_en[1], acc_en[1], acc_en[0], acc_en[0]};

   rr_pick u_rr_pick (
      .eff_req_i (eff_req),
      .last_i    (last_q),
      .found_o   (pick_found),
      .winner_o  (pick_id)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         last_q     <= ID_W'(N_REQ-1);
         busy_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         addr_q     <= '0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_found) begin
                  state_q    <= ARB_BURST;
                  grant_q    <= N_REQ'(1) << pick_id;
                  grant_id_q <= pick_id;
                  last_q     <= pick_id;
                  busy_q     <= 1'b1;
                  beat_cnt_q <= CNT_W'(1);
                  addr_q     <= req_addr[int'(pick_id)*ADDR_W +: ADDR_W];
                  rd_en_q    <= !is_write(pick_id);
                  wr_en_q    <= is_write(pick_id);
               end
            end
            ARB_BURST: begin
               // Drop, mask and limit all collapse into one termination edge.
               if (eff_req[grant_id_q] && (beat_cnt_q < BURST_LIM)) begin
                  addr_q     <= req_addr[int'(grant_id_q)*ADDR_W +: ADDR_W];
                  beat_cnt_q <= beat_cnt_q + CNT_W'(1);
               end else begin
                  state_q    <= ARB_TURN;
                  grant_q    <= '0;
                  busy_q     <= 1'b0;
                  rd_en_q    <= 1'b0;
                  wr_en_q    <= 1'b0;
                  beat_cnt_q <= '0;
               end
            end
            ARB_TURN: begin
               state_q <= ARB_IDLE;
            end
            default: begin
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign grant            = grant_q;
   assign grant_id         = grant_id_q;
   assign busy             = busy_q;
   assign ram_read_enable  = rd_en_q;
   assign ram_write_enable = wr_en_q;
   assign addr             = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// tb_ram_port_arbiter : directed scoreboard bench for ram_port_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;
   import dc_router_pkg::*;

   typedef struct {
      int                cyc;
      int                id;
      logic              wr;
      logic [ADDR_W-1:0] addr;
   } beat_t;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [2:0]              acc_en = '0;
   logic [N_REQ-1:0]        req = '0;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0]        grant;
   logic [ID_W-1:0]         grant_id;
   logic                    busy;
   logic                    ram_read_enable;
   logic                    ram_write_enable;
   logic [ADDR_W-1:0]       addr;

   int    cyc   = 0;
   int    t0    = 0;
   int    n_cmp = 0;
   int    n_err = 0;
   beat_t exp_q[$];

   ram_port_arbiter #(.BURST_MAX(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .acc_en           (acc_en),
      .req              (req),
      .req_addr         (req_addr),
      .grant            (grant),
      .grant_id         (grant_id),
      .busy             (busy),
      .ram_read_enable  (ram_read_enable),
      .ram_write_enable (ram_write_enable),
      .addr             (addr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [ADDR_W-1:0] base(input int i);
      return ADDR_W'(32'h100 + 32'h1000 * i);
   endfunction

   // Each requester presents base + cycles elapsed since the test started.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_addr[i*ADDR_W +: ADDR_W] = base(i) + ADDR_W'(cyc - t0);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // A beat issued on edge n after t0 carries the address sampled one cycle earlier.
   task automatic expect_burst(input int id, input int first_n, input int nbeats);
      beat_t b;
      for (int k = 0; k < nbeats; k++) begin
         b.cyc  = t0 + first_n + k;
         b.id   = id;
         b.wr   = id[0];
         b.addr = base(id) + ADDR_W'(first_n + k - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_grant"},    grant,            0);
      chk({tag, "_grant_id"}, grant_id,         0);
      chk({tag, "_busy"},     busy,             0);
      chk({tag, "_rd_en"},    ram_read_enable,  0);
      chk({tag, "_wr_en"},    ram_write_enable, 0);
      chk({tag, "_addr"},     addr,             0);
   endtask

   task automatic start_test(input string tag, input logic [2:0] en, input logic [N_REQ-1:0] r);
      reset = 1'b1;
      req   = '0;
      step(2);
      reset  = 1'b0;
      check_cleared({tag, "_reset"});
      acc_en = en;
      req    = r;
      t0     = cyc;
   endtask

   // Monitor: every issued beat must match the head of the expected queue.
   always @(negedge clk) begin
      beat_t e;
      if (ram_read_enable || ram_write_enable) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: owner %0d addr %0h at cycle %0d, expected none",
                     grant_id, addr, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("beat_cycle", 64'(cyc), 64'(e.cyc));
            chk("beat_owner", grant_id, 64'(e.id));
            chk("beat_grant", grant, 64'(1) << e.id);
            chk("beat_rd_wr", {ram_write_enable, ram_read_enable}, e.wr ? 2'b10 : 2'b01);
            chk("beat_addr",  addr, e.addr);
            chk("beat_busy",  busy, 1);
         end
      end
   end

   initial begin
      // 1: single reader, 4-beat bursts, turnaround, re-grant to itself
      start_test("t1", 3'b001, 6'b000001);
      expect_burst(0, 1, 4);
      expect_burst(0, 7, 4);
      step(12);
      req = '0;
      step(6);
      chk("t1_drain", exp_q.size(), 0);

      // 2: everyone requesting, full rotation
      start_test("t2", 3'b111, 6'b111111);
      for (int k = 0; k < 7; k++) expect_burst(k % N_REQ, 6*k + 1, 4);
      step(40);
      req = '0;
      step(6);
      chk("t2_drain", exp_q.size(), 0);

      // 3: owner 2 drops after 2 beats, grant moves to 3
      start_test("t3", 3'b111, 6'b001100);
      expect_burst(2, 1, 2);
      expect_burst(3, 5, 4);
      step(2);
      req[2] = 1'b0;
      step(6);
      req = '0;
      step(6);
      chk("t3_drain", exp_q.size(), 0);

      // 4: FIR disabled during fir_wr beat 1; FIR stays locked out
      start_test("t4", 3'b111, 6'b111000);
      expect_burst(3, 1, 1);
      expect_burst(4, 4, 4);
      expect_burst(5, 10, 4);
      expect_burst(4, 16, 4);
      step(1);
      acc_en = 3'b101;
      req[2] = 1'b1;
      step(18);
      req = '0;
      step(6);
      chk("t4_drain", exp_q.size(), 0);

      // 5: burst limit and request drop coincide
      start_test("t5", 3'b001, 6'b000010);
      expect_burst(1, 1, 4);
      step(4);
      req = '0;
      step(8);
      chk("t5_drain", exp_q.size(), 0);

      // 6: async reset in the middle of owner 1's burst
      start_test("t6", 3'b111, 6'b111111);
      expect_burst(0, 1, 4);
      expect_burst(1, 7, 1);
      step(8);
      #1 reset = 1'b1;
      #1 check_cleared("t6_async");
      chk("t6_async_pending", exp_q.size(), 0);
      step(2);
      check_cleared("t6_held");
      reset = 1'b0;
      t0    = cyc;
      expect_burst(0, 1, 4);
      step(4);
      req = '0;
      step(6);
      chk("t6_drain", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
